// File: rtl/cic_dec_ctrl_if.sv
// rtl/cic_dec_ctrl_if.sv - sample/config/control bundle between CIC sequencer and its neighbours (CIC_DROP_CNT_EN adds drop_cnt)
interface cic_dec_ctrl_if;
    logic        enable;
    logic        valid_in;
    logic        cfg_load;
    logic [4:0]  cfg_dec_factor;
    logic        intg_en;
    logic        intg_clr;
    logic        comb_en;
    logic        valid_out;
    logic [3:0]  phase;
    logic [4:0]  dec_factor;
    logic        busy;
    logic        cfg_err;
`ifdef CIC_DROP_CNT_EN
    logic [15:0] drop_cnt;

    modport master (
        output enable, valid_in, cfg_load, cfg_dec_factor,
        input  intg_en, intg_clr, comb_en, valid_out, phase, dec_factor, busy, cfg_err, drop_cnt
    );
    modport slave (
        input  enable, valid_in, cfg_load, cfg_dec_factor,
        output intg_en, intg_clr, comb_en, valid_out, phase, dec_factor, busy, cfg_err, drop_cnt
    );
`else
    modport master (
        output enable, valid_in, cfg_load, cfg_dec_factor,
        input  intg_en, intg_clr, comb_en, valid_out, phase, dec_factor, busy, cfg_err
    );
    modport slave (
        input  enable, valid_in, cfg_load, cfg_dec_factor,
        output intg_en, intg_clr, comb_en, valid_out, phase, dec_factor, busy, cfg_err
    );
`endif
endinterface

// File: rtl/cic_dec_ctrl.sv
// rtl/cic_dec_ctrl.sv - CIC decimator sequencer: enables, flush on reconfiguration, warm-up gated valid (CIC_DROP_CNT_EN adds drop counter)
module cic_dec_ctrl #(
    parameter int Q         = 3,
    parameter int COMB_LAT  = 3,
    parameter int FLUSH_LEN = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    cic_dec_ctrl_if.slave   bus
);
    localparam int WW = (Q > 0) ? $clog2(Q + 1) : 1;
    localparam int FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    state_t         state;
    logic [3:0]     phase_q;
    logic [4:0]     dec_q;
    logic [WW-1:0]  warm_q;
    logic [FW-1:0]  flush_cnt;
    logic           cfg_err_q;

    logic cfg_legal;
    logic load_ok;
    logic accept;
    logic phase_last;
    logic comb_fire;
    logic warm_done;
    logic vo_in;
    logic vo_out;

    always_comb begin
        cfg_legal  = (bus.cfg_dec_factor != 5'd0) &&
                     ((bus.cfg_dec_factor & (bus.cfg_dec_factor - 5'd1)) == 5'd0);
        load_ok    = bus.cfg_load && cfg_legal;
        // a legal reconfiguration pre-empts any sample arriving the same cycle
        accept     = (state == S_RUN) && bus.valid_in && !load_ok;
        phase_last = ({1'b0, phase_q} == (dec_q - 5'd1));
        comb_fire  = accept && phase_last;
        warm_done  = (warm_q == WW'(Q));
        vo_in      = comb_fire && warm_done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            phase_q   <= 4'd0;
            dec_q     <= 5'd1;
            warm_q    <= '0;
            flush_cnt <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= bus.cfg_load && !cfg_legal;
            if (load_ok) begin
                dec_q     <= bus.cfg_dec_factor;
                state     <= S_FLUSH;
                flush_cnt <= FW'(FLUSH_LEN - 1);
                phase_q   <= 4'd0;
                warm_q    <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.enable) state <= S_RUN;
                    end
                    S_RUN: begin
                        if (accept) phase_q <= phase_last ? 4'd0 : phase_q + 4'd1;
                        if (comb_fire && !warm_done) warm_q <= warm_q + WW'(1);
                        if (!bus.enable) state <= S_IDLE;
                    end
                    S_FLUSH: begin
                        if (flush_cnt == '0) state <= bus.enable ? S_RUN : S_IDLE;
                        else                 flush_cnt <= flush_cnt - FW'(1);
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // valid_out tracks comb_en through the comb pipeline; flush discards in-flight results
    generate
        if (COMB_LAT == 0) begin : g_no_lat
            assign vo_out = vo_in;
        end else begin : g_lat
            logic [COMB_LAT-1:0] vo_pipe;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)       vo_pipe <= '0;
                else if (load_ok) vo_pipe <= '0;
                else              vo_pipe <= (vo_pipe >> 1) | (COMB_LAT'(vo_in) << (COMB_LAT - 1));
            end
            assign vo_out = vo_pipe[0];
        end
    endgenerate

`ifdef CIC_DROP_CNT_EN
    logic [15:0] drop_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_q <= 16'd0;
        else if (bus.valid_in && ((state != S_RUN) || load_ok) && (drop_q != 16'hFFFF))
            drop_q <= drop_q + 16'd1;
    end
    assign bus.drop_cnt = drop_q;
`endif

    assign bus.intg_en    = accept;
    assign bus.comb_en    = comb_fire;
    assign bus.intg_clr   = (state == S_FLUSH);
    assign bus.busy       = (state == S_FLUSH);
    assign bus.valid_out  = vo_out;
    assign bus.phase      = phase_q;
    assign bus.dec_factor = dec_q;
    assign bus.cfg_err    = cfg_err_q;
endmodule

// File: tb/tb_cic_dec_ctrl.sv
// tb/tb_cic_dec_ctrl.sv - self-checking bench for cic_dec_ctrl against a cycle-level behavioural model
module tb_cic_dec_ctrl;
    localparam int Q         = 3;
    localparam int COMB_LAT  = 3;
    localparam int FLUSH_LEN = 4;
    localparam int M_IDLE    = 0;
    localparam int M_RUN     = 1;
    localparam int M_FLUSH   = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cic_dec_ctrl_if bus ();

    cic_dec_ctrl #(.Q(Q), .COMB_LAT(COMB_LAT), .FLUSH_LEN(FLUSH_LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    int m_state, m_phase, m_dec, m_warm, m_flush_left, m_drop;
    bit m_err;
    int vo_due[$];
    int cyc = 0;
    int vo_cnt, comb_cnt, busy_cnt, err_cnt;

    function automatic bit is_legal(input int v);
        return (v == 1) || (v == 2) || (v == 4) || (v == 8) || (v == 16);
    endfunction

    task automatic model_reset();
        m_state = M_IDLE; m_phase = 0; m_dec = 1; m_warm = 0;
        m_flush_left = 0; m_drop = 0; m_err = 0;
        vo_due.delete();
    endtask

    task automatic clear_counts();
        vo_cnt = 0; comb_cnt = 0; busy_cnt = 0; err_cnt = 0;
    endtask

    task automatic step(input bit en, input bit vin, input bit ld, input int cfg);
        bit legal, acc, fire, exp_vo;
        @(negedge clk);
        bus.enable = en; bus.valid_in = vin; bus.cfg_load = ld; bus.cfg_dec_factor = cfg[4:0];
        #1;
        legal = ld && is_legal(cfg);
        acc   = (m_state == M_RUN) && vin && !legal;
        fire  = acc && (((m_phase + 1) % m_dec) == 0);
        if (fire && m_warm >= Q) vo_due.push_back(cyc + COMB_LAT);
        exp_vo = (vo_due.size() > 0) && (vo_due[0] == cyc);
        if (exp_vo) void'(vo_due.pop_front());

        check_eq("intg_en",    bus.intg_en,    acc);
        check_eq("comb_en",    bus.comb_en,    fire);
        check_eq("valid_out",  bus.valid_out,  exp_vo);
        check_eq("intg_clr",   bus.intg_clr,   m_state == M_FLUSH);
        check_eq("busy",       bus.busy,       m_state == M_FLUSH);
        check_eq("phase",      bus.phase,      m_phase);
        check_eq("dec_factor", bus.dec_factor, m_dec);
        check_eq("cfg_err",    bus.cfg_err,    m_err);
`ifdef CIC_DROP_CNT_EN
        check_eq("drop_cnt",   bus.drop_cnt,   m_drop);
`endif
        if (bus.valid_out) vo_cnt++;
        if (bus.comb_en)   comb_cnt++;
        if (bus.busy)      busy_cnt++;
        if (bus.cfg_err)   err_cnt++;

        if (vin && (m_state != M_RUN || legal) && m_drop < 65535) m_drop++;
        m_err = ld && !legal;
        if (legal) begin
            m_dec = cfg; m_state = M_FLUSH; m_flush_left = FLUSH_LEN;
            m_phase = 0; m_warm = 0; vo_due.delete();
        end else begin
            case (m_state)
                M_IDLE: if (en) m_state = M_RUN;
                M_RUN: begin
                    if (acc) m_phase = (m_phase + 1) % m_dec;
                    if (fire && m_warm < Q) m_warm++;
                    if (!en) m_state = M_IDLE;
                end
                default: begin
                    m_flush_left--;
                    if (m_flush_left == 0) m_state = en ? M_RUN : M_IDLE;
                end
            endcase
        end
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_intg_en"},  bus.intg_en,    1'b0);
        check_eq({tag, "_intg_clr"}, bus.intg_clr,   1'b0);
        check_eq({tag, "_comb_en"},  bus.comb_en,    1'b0);
        check_eq({tag, "_valid"},    bus.valid_out,  1'b0);
        check_eq({tag, "_busy"},     bus.busy,       1'b0);
        check_eq({tag, "_cfg_err"},  bus.cfg_err,    1'b0);
        check_eq({tag, "_phase"},    bus.phase,      4'd0);
        check_eq({tag, "_dec"},      bus.dec_factor, 5'd1);
`ifdef CIC_DROP_CNT_EN
        check_eq({tag, "_drop"},     bus.drop_cnt,   16'd0);
`endif
    endtask

    int drop_base;

    initial begin
        rst_n = 1'b0;
        bus.enable = 1'b0; bus.valid_in = 1'b0; bus.cfg_load = 1'b0; bus.cfg_dec_factor = 5'd0;
        model_reset();
        clear_counts();
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // factor 1, continuous samples
        step(1, 0, 0, 0);
        clear_counts();
        repeat (10) step(1, 1, 0, 0);
        repeat (6)  step(1, 0, 0, 0);
        check_eq("s1_comb_cnt", comb_cnt, 10);
        check_eq("s1_vo_cnt",   vo_cnt,   7);

        // reconfigure to 8
        clear_counts();
        step(1, 0, 1, 8);
        repeat (4)  step(1, 0, 0, 0);
        repeat (64) step(1, 1, 0, 0);
        repeat (5)  step(1, 0, 0, 0);
        check_eq("s2_busy_cnt", busy_cnt, 4);
        check_eq("s2_comb_cnt", comb_cnt, 8);
        check_eq("s2_vo_cnt",   vo_cnt,   5);

        // illegal factor while running at 4
        step(1, 0, 1, 4);
        repeat (4) step(1, 0, 0, 0);
        clear_counts();
        repeat (5) step(1, 1, 0, 0);
        step(1, 1, 1, 6);
        repeat (6) step(1, 1, 0, 0);
        check_eq("s3_busy_cnt", busy_cnt, 0);
        check_eq("s3_err_cnt",  err_cnt,  1);
        check_eq("s3_comb_cnt", comb_cnt, 3);
        check_eq("s3_dec",      bus.dec_factor, 4);

        // sparse samples, enable dropped mid-phase
        repeat (6) begin
            step(1, 1, 0, 0);
            step(1, 0, 0, 0);
        end
        check_eq("s4_phase_before", bus.phase, 2);
        repeat (5) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        check_eq("s4_phase_resume", bus.phase, 2);
        clear_counts();
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        check_eq("s4_comb_cnt", comb_cnt, 1);

        // load coinciding with sample, reload during flush
        clear_counts();
        step(1, 1, 1, 16);
        step(1, 1, 0, 0);
        step(1, 1, 1, 2);
        repeat (8) step(1, 0, 0, 0);
        check_eq("s5_busy_cnt", busy_cnt, 6);
        check_eq("s5_comb_cnt", comb_cnt, 0);
        check_eq("s5_vo_cnt",   vo_cnt,   0);
        check_eq("s5_dec",      bus.dec_factor, 2);

        // drops in IDLE and FLUSH, then reset in the middle of FLUSH
        step(0, 0, 0, 0);
        drop_base = m_drop;
        repeat (3) step(0, 1, 0, 0);
        step(0, 0, 1, 4);
        repeat (4) step(0, 1, 0, 0);
        step(0, 0, 0, 0);
`ifdef CIC_DROP_CNT_EN
        check_eq("s6_drop_cnt", bus.drop_cnt, drop_base + 7);
`endif
        step(1, 0, 1, 8);
        step(1, 1, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        step(0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic
        repeat (1500) begin
            bit en, vin, ld;
            int cfg;
            en  = ($urandom % 16) != 0;
            vin = $urandom % 2;
            ld  = ($urandom % 40) == 0;
            cfg = (($urandom % 3) == 0) ? int'($urandom % 32) : (1 << ($urandom % 5));
            step(en, vin, ld, cfg);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
